// File: rtl/lpc_pkg.sv
// Shared states and protocol constants for the LPC I/O target.
package lpc_pkg;

   typedef enum logic [3:0] {
      IDLE,
      CYCTYPE,
      ADDR,
      WDATA0,
      WDATA1,
      HTAR0,
      HTAR1,
      SYNC,
      RDATA0,
      RDATA1,
      PTAR0,
      PTAR1,
      IGNORE
   } lpc_state_e;

   localparam logic [3:0]  LPC_START   = 4'h0;
   localparam logic [2:0]  CYC_IO_RD   = 3'b000;
   localparam logic [2:0]  CYC_IO_WR   = 3'b001;
   localparam logic [3:0]  SYNC_READY  = 4'h0;
   localparam logic [3:0]  LAD_IDLE    = 4'hF;
   localparam logic [15:0] PORT80_ADDR = 16'h0080;

endpackage

// File: rtl/lpc_io_target.sv
// LPC I/O-cycle target decoding a 32-byte window into register-file strobes.
// Optional POST-code snoop of port 0x80 is enabled with LPC_PORT80_EN.
module lpc_io_target
   import lpc_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'h0800,
   parameter int          WIN_BITS  = 5
) (
   input  logic       LpcClock,
   input  logic       PciReset,
   input  logic       LpcFrame_n,
   input  logic [3:0] LadIn,
   output logic [3:0] LadOut,
   output logic       LadOe,
   output logic [7:0] Addr,
   output logic       Wr,
   output logic [7:0] DataWr,
   input  logic [7:0] DataRd,
   output logic [7:0] Port80Code
);

   localparam logic [15:0] OFF_MASK = 16'((32'd1 << WIN_BITS) - 32'd1);

   logic [1:0]  rst_sync_q;
   logic        rst_n;
   lpc_state_e  state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [11:0] ioa_q, ioa_d;
   logic        iswr_q, iswr_d;
   logic        hit_q, hit_d;
   logic [7:0]  wdat_q, wdat_d;
   logic [7:0]  rd_q, rd_d;
   logic [7:0]  addr_q, addr_d;
   logic [7:0]  dwr_q, dwr_d;
   logic [15:0] addr_full;
   logic        win_hit;
   logic        oe_m;
   logic [3:0]  lad_m;

   // Async assert, release aligned to LpcClock
   always_ff @(posedge LpcClock or negedge PciReset) begin
      if (!PciReset) rst_sync_q <= 2'b00;
      else           rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   assign addr_full = {ioa_q, LadIn};
   assign win_hit   = (addr_full & ~OFF_MASK) == (BASE_ADDR & ~OFF_MASK);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ioa_d   = ioa_q;
      iswr_d  = iswr_q;
      hit_d   = hit_q;
      wdat_d  = wdat_q;
      rd_d    = rd_q;
      addr_d  = addr_q;
      dwr_d   = dwr_q;
      if (!LpcFrame_n) begin
         state_d = (LadIn == LPC_START) ? CYCTYPE : IDLE;
         cnt_d   = 2'd0;
         hit_d   = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: ;
            CYCTYPE: begin
               cnt_d = 2'd0;
               hit_d = 1'b0;
               if (LadIn[3:1] == CYC_IO_RD) begin
                  iswr_d  = 1'b0;
                  state_d = ADDR;
               end else if (LadIn[3:1] == CYC_IO_WR) begin
                  iswr_d  = 1'b1;
                  state_d = ADDR;
               end else begin
                  state_d = IGNORE;
               end
            end
            ADDR: begin
               ioa_d = addr_full[11:0];
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  hit_d   = win_hit;
                  state_d = iswr_q ? WDATA0 : HTAR0;
                  if (win_hit) addr_d = 8'(addr_full & OFF_MASK);
               end
            end
            WDATA0: begin
               wdat_d[3:0] = LadIn;
               state_d     = WDATA1;
            end
            WDATA1: begin
               wdat_d[7:4] = LadIn;
               if (hit_q) dwr_d = {LadIn, wdat_q[3:0]};
               state_d = HTAR0;
            end
            HTAR0:  state_d = HTAR1;
            HTAR1: begin
               if (!iswr_q) rd_d = DataRd;
               state_d = SYNC;
            end
            SYNC:   state_d = iswr_q ? PTAR0 : RDATA0;
            RDATA0: state_d = RDATA1;
            RDATA1: state_d = PTAR0;
            PTAR0:  state_d = PTAR1;
            PTAR1:  state_d = IDLE;
            IGNORE: ;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge LpcClock or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         ioa_q   <= 12'h000;
         iswr_q  <= 1'b0;
         hit_q   <= 1'b0;
         wdat_q  <= 8'h00;
         rd_q    <= 8'h00;
         addr_q  <= 8'h00;
         dwr_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ioa_q   <= ioa_d;
         iswr_q  <= iswr_d;
         hit_q   <= hit_d;
         wdat_q  <= wdat_d;
         rd_q    <= rd_d;
         addr_q  <= addr_d;
         dwr_q   <= dwr_d;
      end
   end

   // Host abort (LFRAME# low) kills drive and strobe in the same clock
   assign oe_m = hit_q && (state_q == SYNC || state_q == RDATA0 ||
                           state_q == RDATA1 || state_q == PTAR0);

   always_comb begin
      lad_m = LAD_IDLE;
      case (state_q)
         SYNC:    lad_m = SYNC_READY;
         RDATA0:  lad_m = rd_q[3:0];
         RDATA1:  lad_m = rd_q[7:4];
         default: lad_m = LAD_IDLE;
      endcase
   end

   assign LadOe  = oe_m && LpcFrame_n;
   assign LadOut = LadOe ? lad_m : LAD_IDLE;
   assign Wr     = hit_q && iswr_q && (state_q == HTAR0) && LpcFrame_n;
   assign Addr   = addr_q;
   assign DataWr = dwr_q;

`ifdef LPC_PORT80_EN
   logic       p80_q, p80_d;
   logic [7:0] p80c_q, p80c_d;

   always_comb begin
      p80_d  = p80_q;
      p80c_d = p80c_q;
      if (!LpcFrame_n) begin
         p80_d = 1'b0;
      end else if (state_q == ADDR && cnt_q == 2'd3) begin
         p80_d = iswr_q && (addr_full == PORT80_ADDR);
      end else if (state_q == HTAR0 && p80_q) begin
         p80c_d = wdat_q;
      end
   end

   always_ff @(posedge LpcClock or negedge rst_n) begin
      if (!rst_n) begin
         p80_q  <= 1'b0;
         p80c_q <= 8'h00;
      end else begin
         p80_q  <= p80_d;
         p80c_q <= p80c_d;
      end
   end

   assign Port80Code = p80c_q;
`else
   assign Port80Code = 8'h00;
`endif

endmodule

// File: tb/tb_lpc_io_target.sv
// Scoreboard bench for lpc_io_target: expected Wr/LAD events queued, monitor compares.
module tb_lpc_io_target;

   typedef struct {
      bit         is_wr;
      logic [7:0] a;
      logic [7:0] d;
      logic [3:0] lad;
   } exp_t;

   logic       clk = 1'b0;
   logic       PciReset;
   logic       LpcFrame_n;
   logic [3:0] LadIn;
   logic [3:0] LadOut;
   logic       LadOe;
   logic [7:0] Addr;
   logic       Wr;
   logic [7:0] DataWr;
   logic [7:0] DataRd;
   logic [7:0] Port80Code;

   logic [7:0] rf [32];
   exp_t       q[$];
   int         total = 0;
   int         bad   = 0;
   bit         mon_en = 1'b0;

   always #15 clk = ~clk;

   assign DataRd = rf[Addr[4:0]];

   lpc_io_target dut (
      .LpcClock   (clk),
      .PciReset   (PciReset),
      .LpcFrame_n (LpcFrame_n),
      .LadIn      (LadIn),
      .LadOut     (LadOut),
      .LadOe      (LadOe),
      .Addr       (Addr),
      .Wr         (Wr),
      .DataWr     (DataWr),
      .DataRd     (DataRd),
      .Port80Code (Port80Code)
   );

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
      exp_t e;
      e.is_wr = 1'b1; e.a = a; e.d = d; e.lad = 4'h0;
      q.push_back(e);
   endtask

   task automatic push_lad(input logic [3:0] v);
      exp_t e;
      e.is_wr = 1'b0; e.a = 8'h00; e.d = 8'h00; e.lad = v;
      q.push_back(e);
   endtask

   task automatic nib(input logic fr, input logic [3:0] v);
      @(posedge clk);
      #2;
      LpcFrame_n = fr;
      LadIn      = v;
   endtask

   task automatic hdr(input logic [3:0] cyc, input logic [15:0] a);
      nib(1'b0, 4'h0);
      nib(1'b1, cyc);
      for (int i = 3; i >= 0; i--) nib(1'b1, a[i*4 +: 4]);
   endtask

   task automatic io_wr(input logic [15:0] a, input logic [7:0] d);
      hdr(4'h2, a);
      nib(1'b1, d[3:0]);
      nib(1'b1, d[7:4]);
      repeat (6) nib(1'b1, 4'hF);
   endtask

   task automatic io_rd(input logic [15:0] a);
      hdr(4'h0, a);
      repeat (8) nib(1'b1, 4'hF);
   endtask

   // Monitor: every Wr or LadOe clock must match the head of the queue
   always @(negedge clk) begin
      if (mon_en && (Wr || LadOe)) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious: got Wr=%b LadOe=%b LadOut=%h want idle",
                     Wr, LadOe, LadOut);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("ev_kind", {15'd0, Wr}, {15'd0, e.is_wr});
            if (Wr) begin
               chk("wr_addr", {8'd0, Addr}, {8'd0, e.a});
               chk("wr_data", {8'd0, DataWr}, {8'd0, e.d});
               chk("wr_no_oe", {15'd0, LadOe}, 16'd0);
            end else begin
               chk("lad", {12'd0, LadOut}, {12'd0, e.lad});
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 8'(i * 7 + 1);
      rf[4] = 8'h03;
      rf[5] = 8'hE2;
      rf[6] = 8'h9C;
      PciReset   = 1'b0;
      LpcFrame_n = 1'b1;
      LadIn      = 4'hF;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_oe", {15'd0, LadOe}, 16'd0);
      chk("rst_lad", {12'd0, LadOut}, 16'h000F);
      chk("rst_wr", {15'd0, Wr}, 16'd0);
      chk("rst_addr", {8'd0, Addr}, 16'd0);
      chk("rst_dwr", {8'd0, DataWr}, 16'd0);
      chk("rst_p80", {8'd0, Port80Code}, 16'd0);
      PciReset = 1'b1;
      repeat (3) @(posedge clk);
      mon_en = 1'b1;

      // write hit
      push_wr(8'h01, 8'hA5);
      push_lad(4'h0);
      push_lad(4'hF);
      io_wr(16'h0801, 8'hA5);
      chk("t1_addr", {8'd0, Addr}, 16'h0001);
      chk("t1_dwr", {8'd0, DataWr}, 16'h00A5);

      // read hit
      push_lad(4'h0);
      push_lad(4'h3);
      push_lad(4'h0);
      push_lad(4'hF);
      io_rd(16'h0804);
      chk("t2_addr", {8'd0, Addr}, 16'h0004);

      // write miss
      io_wr(16'h0900, 8'h11);
      chk("t3_addr", {8'd0, Addr}, 16'h0004);
      chk("t3_dwr", {8'd0, DataWr}, 16'h00A5);

      // read hit aborted in SYNC: no drive at all
      hdr(4'h0, 16'h0805);
      nib(1'b1, 4'hF);
      nib(1'b1, 4'hF);
      nib(1'b0, 4'hF);
      repeat (3) nib(1'b1, 4'hF);
      chk("ab_addr", {8'd0, Addr}, 16'h0005);

      // abort after 2nd address nibble, then a clean write
      nib(1'b0, 4'h0);
      nib(1'b1, 4'h2);
      nib(1'b1, 4'h0);
      nib(1'b1, 4'h8);
      nib(1'b0, 4'hF);
      repeat (2) nib(1'b1, 4'hF);
      chk("t4_addr", {8'd0, Addr}, 16'h0005);
      push_wr(8'h02, 8'h3C);
      push_lad(4'h0);
      push_lad(4'hF);
      io_wr(16'h0802, 8'h3C);
      chk("t4_dwr", {8'd0, DataWr}, 16'h003C);

      // memory read cycle is ignored
      hdr(4'h4, 16'h0800);
      repeat (10) nib(1'b1, 4'hF);
      chk("t5_addr", {8'd0, Addr}, 16'h0002);

      // reset during RDATA0
      push_lad(4'h0);
      hdr(4'h0, 16'h0806);
      repeat (3) nib(1'b1, 4'hF);
      @(posedge clk);
      #5;
      PciReset = 1'b0;
      #1;
      chk("t6_oe", {15'd0, LadOe}, 16'd0);
      chk("t6_lad", {12'd0, LadOut}, 16'h000F);
      chk("t6_addr", {8'd0, Addr}, 16'd0);
      chk("t6_dwr", {8'd0, DataWr}, 16'd0);
      repeat (2) @(posedge clk);
      #2;
      PciReset = 1'b1;
      repeat (3) @(posedge clk);
      push_wr(8'h01, 8'h77);
      push_lad(4'h0);
      push_lad(4'hF);
      io_wr(16'h0801, 8'h77);
      chk("t6_resume", {8'd0, Addr}, 16'h0001);

      // port 0x80 snoop
      io_wr(16'h0080, 8'h5A);
`ifdef LPC_PORT80_EN
      chk("t7_p80", {8'd0, Port80Code}, 16'h005A);
`else
      chk("t7_p80", {8'd0, Port80Code}, 16'h0000);
`endif
      chk("t7_addr", {8'd0, Addr}, 16'h0001);

      repeat (4) nib(1'b1, 4'hF);
      chk("drain", 16'(q.size()), 16'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
